// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU arbiter slice:
//   - fsm_state_t : arbiter control states
//   - ERR_*       : values carried on rsp_error
//   - OP_*        : FPU command encodings seen on fpu_command
// -----------------------------------------------------------------------------
package fpu_pkg;

  // Arbiter control flow: pick a client, launch the FPU, wait, hand back.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } fsm_state_t;

  // Response error codes.
  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  // FPU command encodings (command_size = 2).
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage : fpu_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the request vector starting
// one position after the previous winner and wrapping, so the client that was
// just served has the lowest priority.
//
// Ports
//   i_req    [requesters-1:0]  request vector
//   i_last   [IDX_W-1:0]       index of the previous winner
//   o_grant  [IDX_W-1:0]       index of the new winner (valid when o_any)
//   o_any                      at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int requesters = 4,
  localparam int IDX_W     = $clog2(requesters)
) (
  input  logic [requesters-1:0] i_req,
  input  logic [IDX_W-1:0]      i_last,
  output logic [IDX_W-1:0]      o_grant,
  output logic                  o_any
);

  // One extra bit so last+offset never overflows before the wrap.
  logic [IDX_W:0]   w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;

  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would make synthesis infer a latch.
    w_cand  = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= requesters; k++) begin
      w_cand = {1'b0, i_last} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(requesters)) begin
        w_cand = w_cand - (IDX_W+1)'(requesters);
      end
      if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_W-1:0];
      end
    end
  end

  assign o_grant = w_pick;
  assign o_any   = w_found;

endmodule : rr_arbiter

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Shares a single multi-cycle FPU between several clients. One operation is in
// flight at a time; clients are served round-robin. A watchdog bounds the wait
// for the FPU and returns an error response if it never completes.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid   [R-1:0]          per-client request
//   req_first   [R*B-1:0]        packed first operands, client i at [i*B +: B]
//   req_second  [R*B-1:0]        packed second operands
//   req_command [R*C-1:0]        packed commands, client i at [i*C +: C]
//   req_ready   [R-1:0]          one-hot accept strobe (cycle of grant)
//   rsp_valid   [R-1:0]          one-hot response valid to the owning client
//   rsp_ready   [R-1:0]          per-client response accept
//   rsp_result  [B-1:0]          result (0 on timeout)
//   rsp_error                    1 = FPU timed out
//   fpu_first, fpu_second [B-1:0], fpu_command [C-1:0]  operands to the FPU
//   fpu_start                    single-cycle launch pulse
//   fpu_result  [B-1:0]          FPU result
//   fpu_work_is_done             FPU completion
// -----------------------------------------------------------------------------
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int bitness        = 32,
  parameter int command_size   = 2,
  parameter int requesters     = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [requesters-1:0]            req_valid,
  input  logic [requesters*bitness-1:0]    req_first,
  input  logic [requesters*bitness-1:0]    req_second,
  input  logic [requesters*command_size-1:0] req_command,
  output logic [requesters-1:0]            req_ready,
  output logic [requesters-1:0]            rsp_valid,
  input  logic [requesters-1:0]            rsp_ready,
  output logic [bitness-1:0]               rsp_result,
  output logic                             rsp_error,
  output logic [bitness-1:0]               fpu_first,
  output logic [bitness-1:0]               fpu_second,
  output logic [command_size-1:0]          fpu_command,
  output logic                             fpu_start,
  input  logic [bitness-1:0]               fpu_result,
  input  logic                             fpu_work_is_done
);

  localparam int GW = $clog2(requesters);
  localparam int CW = $clog2(timeout_cycles);
  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [CW-1:0] COUNT_LAST = CW'(timeout_cycles - 1);

  fsm_state_t              r_state;
  fsm_state_t              w_next_state;

  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last;
  logic [GW-1:0]           w_grant;
  logic                    w_any;

  logic [bitness-1:0]      r_first;
  logic [bitness-1:0]      r_second;
  logic [command_size-1:0] r_command;
  logic [bitness-1:0]      r_result;
  logic                    r_error;
  logic [CW-1:0]           r_count;

  logic                    w_timeout;
  logic                    w_rsp_accept;

  // ---------------------------------------------------------------------------
  // Round-robin pick among pending requests
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .requesters (requesters)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_timeout    = (r_count == COUNT_LAST);
  // Only the owning client can retire the response.
  assign w_rsp_accept = rsp_ready[r_grant];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_WAIT;
      // Completion wins over the watchdog in the last permitted cycle.
      ST_WAIT:    if (fpu_work_is_done || w_timeout) w_next_state = ST_RESPOND;
      ST_RESPOND: if (w_rsp_accept) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Strobes are forced low while reset is held so a client is never told it was
  // accepted by an operation the reset is about to discard.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    fpu_start = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE:    if (w_any) req_ready[w_grant] = 1'b1;
        ST_ISSUE:   fpu_start = 1'b1;
        ST_RESPOND: rsp_valid[r_grant] = 1'b1;
        default:    ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, watchdog, response capture, fairness pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant   <= '0;
      // Previous winner = last client, so client 0 is first after reset.
      r_last    <= GW'(requesters - 1);
      r_first   <= '0;
      r_second  <= '0;
      r_command <= '0;
      r_result  <= '0;
      r_error   <= ERR_NONE;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant   <= w_grant;
            r_first   <= req_first[int'(w_grant)*bitness +: bitness];
            r_second  <= req_second[int'(w_grant)*bitness +: bitness];
            r_command <= req_command[int'(w_grant)*command_size +: command_size];
          end
        end
        ST_ISSUE: begin
          r_count <= '0;
        end
        ST_WAIT: begin
          if (fpu_work_is_done) begin
            r_result <= fpu_result;
            r_error  <= ERR_NONE;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= ERR_TIMEOUT;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_RESPOND: begin
          if (w_rsp_accept) begin
            r_last <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  // Operands stay on the FPU bus from ISSUE through WAIT because they only
  // change on a new grant in IDLE.
  assign fpu_first   = r_first;
  assign fpu_second  = r_second;
  assign fpu_command = r_command;
  assign rsp_result  = r_result;
  assign rsp_error   = r_error;

endmodule : fpu_arbiter

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
// Directed, table-driven bench for fpu_arbiter with a small FPU model whose
// completion delay and result are set per operation. Delay 0 asserts done in
// the ISSUE cycle only; a negative delay never completes.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int BW = 32;
  localparam int CS = 2;
  localparam int NR = 4;
  localparam int TO = 64;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_first;
  logic [NR*BW-1:0]  req_second;
  logic [NR*CS-1:0]  req_command;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [BW-1:0]     rsp_result;
  logic              rsp_error;
  logic [BW-1:0]     fpu_first;
  logic [BW-1:0]     fpu_second;
  logic [CS-1:0]     fpu_command;
  logic              fpu_start;
  logic [BW-1:0]     fpu_result;
  logic              fpu_work_is_done;

  fpu_arbiter #(
    .bitness        (BW),
    .command_size   (CS),
    .requesters     (NR),
    .timeout_cycles (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_first        (req_first),
    .req_second       (req_second),
    .req_command      (req_command),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_error        (rsp_error),
    .fpu_first        (fpu_first),
    .fpu_second       (fpu_second),
    .fpu_command      (fpu_command),
    .fpu_start        (fpu_start),
    .fpu_result       (fpu_result),
    .fpu_work_is_done (fpu_work_is_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs are driven at posedge+3, outputs sampled at posedge+4.
  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // ---------------------------------------------------------------------------
  // FPU model: acts at posedge+2, between DUT update and bench drive.
  // ---------------------------------------------------------------------------
  int            model_delay;
  logic [BW-1:0] model_ret;
  int            pending;

  initial begin
    fpu_work_is_done = 1'b0;
    fpu_result       = '0;
    pending          = 0;
    forever begin
      @(posedge clock);
      #2;
      fpu_work_is_done = 1'b0;
      if (fpu_start) begin
        if (model_delay == 0) begin
          fpu_work_is_done = 1'b1;
          fpu_result       = model_ret;
        end else if (model_delay > 0) begin
          pending = model_delay;
        end
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          fpu_work_is_done = 1'b1;
          fpu_result       = model_ret;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NR-1:0] valid;
    logic [BW-1:0] first;
    logic [BW-1:0] second;
    logic [CS-1:0] cmd;
    logic [BW-1:0] ret;
    int            delay;
    int            grant;
    logic [BW-1:0] exp_result;
    logic          exp_error;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  // Runs one operation starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic apply_vec(input vec_t v, input int idx);
    logic [NR-1:0] exp_oh;
    int            cyc;
    int            exp_lat;
    int            starts;
    logic          stable;
    exp_oh  = NR'(1) << v.grant;
    exp_lat = (v.delay >= 1 && v.delay <= TO) ? 2 + v.delay : 2 + TO;
    for (int i = 0; i < NR; i++) begin
      req_first[i*BW +: BW]   = (i == v.grant) ? v.first  : ~v.first;
      req_second[i*BW +: BW]  = (i == v.grant) ? v.second : ~v.second;
      req_command[i*CS +: CS] = (i == v.grant) ? v.cmd    : ~v.cmd;
    end
    req_valid   = v.valid;
    rsp_ready   = '1;
    model_delay = v.delay;
    model_ret   = v.ret;
    #1;
    check($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'(exp_oh));
    tick();
    #1;
    check($sformatf("v%0d fpu_start", idx), 64'(fpu_start), 64'(1'b1));
    check($sformatf("v%0d fpu_first", idx), 64'(fpu_first), 64'(v.first));
    check($sformatf("v%0d fpu_second", idx), 64'(fpu_second), 64'(v.second));
    check($sformatf("v%0d fpu_command", idx), 64'(fpu_command), 64'(v.cmd));
    tick();
    #1;
    cyc    = 2;
    starts = 0;
    stable = 1'b1;
    while (rsp_valid == '0 && cyc < 100) begin
      if (fpu_first !== v.first || fpu_second !== v.second || fpu_command !== v.cmd) stable = 1'b0;
      if (fpu_start) starts++;
      if (req_ready != '0) stable = 1'b0;
      tick();
      #1;
      cyc++;
    end
    check($sformatf("v%0d latency", idx), 64'(cyc), 64'(exp_lat));
    check($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'(exp_oh));
    check($sformatf("v%0d rsp_result", idx), 64'(rsp_result), 64'(v.exp_result));
    check($sformatf("v%0d rsp_error", idx), 64'(rsp_error), 64'(v.exp_error));
    check($sformatf("v%0d fpu bus stable", idx), 64'(stable), 64'(1'b1));
    check($sformatf("v%0d single start", idx), 64'(starts), 64'(0));
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [BW-1:0] held;
    logic          quiet;

    // Round-robin from reset: 0,1,2,3,0 with all requesting.
    tbl[0]  = '{4'b1111, 32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 1, 0, 32'h40000000, 1'b0};
    tbl[1]  = '{4'b1111, 32'h40400000, 32'h40000000, OP_SUB, 32'h3F800000, 2, 1, 32'h3F800000, 1'b0};
    tbl[2]  = '{4'b1111, 32'h40000000, 32'h40400000, OP_MUL, 32'h40C00000, 3, 2, 32'h40C00000, 1'b0};
    tbl[3]  = '{4'b1111, 32'h40C00000, 32'h40000000, OP_DIV, 32'h40400000, 1, 3, 32'h40400000, 1'b0};
    tbl[4]  = '{4'b1111, 32'hBF800000, 32'h3F800000, OP_ADD, 32'h00000000, 4, 0, 32'h00000000, 1'b0};
    // Partial request sets: search starts after the last winner and wraps.
    tbl[5]  = '{4'b1010, 32'h41200000, 32'h40A00000, OP_SUB, 32'h40A00000, 1, 1, 32'h40A00000, 1'b0};
    tbl[6]  = '{4'b1010, 32'h40A00000, 32'h40A00000, OP_MUL, 32'h41C80000, 2, 3, 32'h41C80000, 1'b0};
    tbl[7]  = '{4'b0001, 32'h3F000000, 32'h3F000000, OP_ADD, 32'h3F800000, 1, 0, 32'h3F800000, 1'b0};
    // 1.0 + 2.0 = 3.0 with minimum latency, then the same client back-to-back.
    tbl[8]  = '{4'b0100, 32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1, 2, 32'h40400000, 1'b0};
    tbl[9]  = '{4'b0100, 32'h40400000, 32'h3F800000, OP_ADD, 32'h40800000, 1, 2, 32'h40800000, 1'b0};
    tbl[10] = '{4'b1001, 32'h41000000, 32'h40000000, OP_DIV, 32'h40800000, 5, 3, 32'h40800000, 1'b0};
    // Done only during ISSUE is ignored -> timeout.
    tbl[11] = '{4'b0001, 32'h3F800000, 32'h3F800000, OP_MUL, 32'hDEADBEEF, 0, 0, 32'h00000000, 1'b1};
    // FPU never completes -> timeout.
    tbl[12] = '{4'b0010, 32'h40000000, 32'h40000000, OP_ADD, 32'h12345678, -1, 1, 32'h00000000, 1'b1};
    // Done in the last permitted WAIT cycle wins over the timeout.
    tbl[13] = '{4'b0100, 32'h42000000, 32'h40000000, OP_MUL, 32'h42800000, TO, 2, 32'h42800000, 1'b0};
    // Done one cycle too late -> timeout, late done ignored in RESPOND.
    tbl[14] = '{4'b1000, 32'h3F800000, 32'h00000000, OP_DIV, 32'h55555555, TO + 1, 3, 32'h00000000, 1'b1};

    // Reset with requests already pending.
    reset       = 1'b1;
    req_valid   = '1;
    req_first   = '1;
    req_second  = '1;
    req_command = '1;
    rsp_ready   = '1;
    model_delay = -1;
    model_ret   = '0;
    tick();
    tick();
    tick();
    #1;
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset fpu_start", 64'(fpu_start), 64'(0));
    check("reset fpu_first", 64'(fpu_first), 64'(0));
    check("reset fpu_second", 64'(fpu_second), 64'(0));
    check("reset fpu_command", 64'(fpu_command), 64'(0));
    check("reset rsp_result", 64'(rsp_result), 64'(0));
    check("reset rsp_error", 64'(rsp_error), 64'(0));
    tick();
    reset     = 1'b0;
    req_valid = '0;

    for (int i = 0; i < NV; i++) apply_vec(tbl[i], i);

    // Backpressure: client 1 withholds rsp_ready for 5 cycles while the others
    // assert theirs and everybody requests.
    for (int i = 0; i < NR; i++) begin
      req_first[i*BW +: BW]   = (i == 1) ? 32'h40A00000 : 32'h0;
      req_second[i*BW +: BW]  = (i == 1) ? 32'hC1200000 : 32'h0;
      req_command[i*CS +: CS] = OP_ADD;
    end
    req_valid   = 4'b0010;
    rsp_ready   = 4'b1101;
    model_delay = 1;
    model_ret   = 32'hC0A00000;
    #1;
    check("bp req_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    tick();
    tick();
    #1;
    check("bp rsp_valid first", 64'(rsp_valid), 64'(4'b0010));
    check("bp rsp_result first", 64'(rsp_result), 64'(32'hC0A00000));
    held      = rsp_result;
    req_valid = '1;
    quiet     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      if (rsp_valid !== 4'b0010 || rsp_result !== 32'hC0A00000 || req_ready !== '0 || fpu_start !== 1'b0)
        quiet = 1'b0;
    end
    check("bp held stable", 64'(quiet), 64'(1'b1));
    check("bp result held", 64'(rsp_result), 64'(held));
    rsp_ready = '1;
    tick();
    #1;
    // Client 1 served last, so client 2 is next.
    check("bp next grant", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;

    // Reset while waiting on the FPU; its done then arrives in IDLE.
    tick();
    for (int i = 0; i < NR; i++) begin
      req_first[i*BW +: BW]  = 32'h11111111;
      req_second[i*BW +: BW] = 32'h22222222;
    end
    req_valid   = 4'b0100;
    model_delay = 6;
    model_ret   = 32'h77777777;
    #1;
    check("rw req_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rw rsp_valid in reset", 64'(rsp_valid), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    check("rw fpu_first cleared", 64'(fpu_first), 64'(0));
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      if (rsp_valid !== '0 || fpu_start !== 1'b0 || req_ready !== '0) quiet = 1'b0;
    end
    check("rw no stale response", 64'(quiet), 64'(1'b1));
    req_valid = '1;
    #1;
    check("rw next grant client0", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fpu_arbiter

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter bitness, default 32, operand/result width passed to the FPU.
REQ-002 SHALL have parameter command_size, default 2, FPU command width.
REQ-003 SHALL have parameter requesters, default 4, number of clients sharing one FPU (2..8).
REQ-004 SHALL have parameter timeout_cycles, default 64, max cycles waiting for FPU completion (≥2).
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  requesters  per-client operation request.
REQ-008 SHALL have port req_first, req_second  input  requesters*bitness each  packed operands, client i at [i*bitness +: bitness].
REQ-009 SHALL have port req_command  input  requesters*command_size  packed commands.
REQ-010 SHALL have port req_ready  output  requesters  one-hot accept strobe.
REQ-011 SHALL have port rsp_valid  output  requesters  one-hot response-valid to the owning client.
REQ-012 SHALL have port rsp_ready  input  requesters  per-client response accept.
REQ-013 SHALL have ports rsp_result  output  bitness  result; rsp_error  output  1  timeout flag.
REQ-014 SHALL have ports fpu_first, fpu_second  output  bitness; fpu_command  output  command_size; fpu_start  output  1  single-cycle launch pulse.
REQ-015 SHALL have ports fpu_result  input  bitness; fpu_work_is_done  input  1  FPU completion.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
REQ-017 IDLE: if any req_valid, SHALL grant round-robin starting at (last_grant+1) mod requesters, assert req_ready[grant] that cycle, latch operands/command, go to ISSUE.
REQ-018 ISSUE: SHALL drive latched operands on fpu_* and pulse fpu_start for exactly one cycle, clear timeout counter, go to WAIT.
REQ-019 WAIT: on fpu_work_is_done SHALL latch fpu_result, rsp_error=0, go to RESPOND; done in the ISSUE cycle SHALL be ignored.
REQ-020 WAIT: counter increments each cycle; on reaching timeout_cycles without done SHALL set rsp_result=0, rsp_error=1, go to RESPOND.
REQ-021 RESPOND: SHALL hold rsp_valid[grant], rsp_result, rsp_error stable until rsp_ready[grant]; then update last_grant=grant and return to IDLE.
REQ-022 rsp_ready of non-granted clients SHALL be ignored; req_valid changes outside IDLE SHALL have no effect.
REQ-023 Minimum request-to-rsp_valid latency SHALL be 3 cycles (done in first WAIT cycle); one operation in flight max.
REQ-024 Single requester asserting continuously SHALL be served back-to-back; with all asserting, each SHALL be served once per requesters operations (no starvation).
REQ-025 fpu_first/second/command SHALL remain stable from ISSUE through WAIT.

Reset
REQ-026 On reset SHALL enter IDLE; req_ready, rsp_valid, fpu_start=0; rsp_result, rsp_error, fpu_* data=0; last_grant=requesters-1 (so client 0 wins first).
REQ-027 Reset mid-WAIT/RESPOND SHALL abandon the operation without response; a later stale fpu_work_is_done in IDLE SHALL be ignored.

Structure
REQ-028 SHALL place FSM state enum and error code constants in shared package fpu_pkg with the FPU opcode encodings.
REQ-029 SHALL instantiate one sub-module rr_arbiter (combinational round-robin pick from request vector and last_grant).

Verification
REQ-030 Single op: reset, req_valid[2]=1, first=0x3F800000, second=0x40000000, FPU model done after 1 cycle with 0x40400000 -> req_ready[2] one cycle, fpu_start one pulse, rsp_valid[2] at cycle 3, rsp_result=0x40400000, rsp_error=0.
REQ-031 Fairness: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-032 Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_result stable, no new grant until accepted.
REQ-033 Timeout: FPU never asserts done, timeout_cycles=64 -> rsp_valid after 64 WAIT cycles, rsp_result=0, rsp_error=1.
REQ-034 Reset in WAIT: assert reset, then late fpu_work_is_done -> no rsp_valid, state IDLE, next grant client 0.
